// File: rtl/adc_sample_scheduler_if.sv
// ADC reader handshake bundle for the capture scheduler.
// Ports: adc_req/adc_ch (request), adc_done/adc_data (result).
interface adc_sample_scheduler_if;
    logic        adc_req;
    logic [1:0]  adc_ch;
    logic        adc_done;
    logic [11:0] adc_data;

    modport master (
        output adc_req, adc_ch,
        input  adc_done, adc_data
    );

    modport slave (
        input  adc_req, adc_ch,
        output adc_done, adc_data
    );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Paces ADC conversions, scans enabled channels round-robin and writes
// samples into the capture ring; stops POST_CNT writes after a rising-edge
// trigger. Ports: clk, rst (async, active-high); i_arm, i_ch_mask,
// i_trig_ch, i_trig_level, i_rate_div (control); adc_if (ADC reader,
// master side); o_wr_en/o_wr_addr/o_wr_data (capture RAM);
// o_trig_addr, o_capturing, o_capture_done, o_overrun, o_timeout_err.
// Optional macro ADC_TIMEOUT_EN adds a WAIT_DONE watchdog.
module adc_sample_scheduler #(
    parameter int ADDR_W      = 10,
    parameter int POST_CNT    = 512,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_arm,
    input  logic [3:0]            i_ch_mask,
    input  logic [1:0]            i_trig_ch,
    input  logic [11:0]           i_trig_level,
    input  logic [15:0]           i_rate_div,
    adc_sample_scheduler_if.master adc_if,
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [13:0]           o_wr_data,
    output logic [ADDR_W-1:0]     o_trig_addr,
    output logic                  o_capturing,
    output logic                  o_capture_done,
    output logic                  o_overrun,
    output logic                  o_timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_REQ, S_WAIT_DONE, S_STORE, S_DONE
    } state_t;

    localparam int PC_W = $clog2(POST_CNT + 1);

    state_t            r_state, w_next;
    logic [15:0]       r_div;
    logic [1:0]        r_ch;
    logic [11:0]       r_sample, r_prev;
    logic              r_prev_valid, r_triggered;
    logic [PC_W-1:0]   r_post;
    logic [ADDR_W-1:0] r_addr, r_trig_addr;
    logic              r_capturing, r_done, r_overrun;

    logic              w_tick, w_fire, w_trig_now, w_last, w_timeout;
    logic              w_req, w_wr_en;
    logic [3:0]        w_above_mask;
    logic [2:0]        w_first, w_above;

    // {found, channel} of the lowest set bit
    function automatic logic [2:0] f_lowest(input logic [3:0] m);
        logic [2:0] v;
        v = '0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) v = {1'b1, i[1:0]};
        return v;
    endfunction

    assign w_tick       = r_capturing && (r_div == i_rate_div);
    assign w_above_mask = 4'b1110 << r_ch;
    assign w_first      = f_lowest(i_ch_mask);
    assign w_above      = f_lowest(i_ch_mask & w_above_mask);

    // Rising crossing needs a valid previous sample on the trigger channel
    assign w_fire = (r_ch == i_trig_ch) && !r_triggered && r_prev_valid
                  && (r_prev < i_trig_level) && (r_sample >= i_trig_level);
    assign w_trig_now = r_triggered || w_fire;
    assign w_last = w_trig_now && (r_post == PC_W'(POST_CNT - 1));

`ifdef ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to;
    logic            r_timeout_err;

    assign w_timeout = (r_state == S_WAIT_DONE) && !adc_if.adc_done
                     && (r_to == TO_W'(TIMEOUT_CYC - 1));
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to <= (r_state == S_WAIT_DONE) ? r_to + 1'b1 : '0;
            if ((r_state == S_IDLE || r_state == S_DONE) && i_arm)
                r_timeout_err <= 1'b0;
            else if (w_timeout)
                r_timeout_err <= 1'b1;
        end
    end
`else
    // Keeps the watchdog parameter referenced when the counter is absent
    logic [31:0] w_unused_to;
    assign w_unused_to   = 32'(TIMEOUT_CYC);
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_wr_en = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_arm) w_next = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (w_tick && w_first[2]) w_next = S_REQ;
            end
            S_REQ: begin
                w_req  = 1'b1;
                w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (adc_if.adc_done)
                    w_next = S_STORE;
                else if (w_timeout)
                    w_next = w_above[2] ? S_REQ : S_WAIT_TICK;
            end
            S_STORE: begin
                w_wr_en = 1'b1;
                if (w_last)
                    w_next = S_DONE;
                else
                    w_next = w_above[2] ? S_REQ : S_WAIT_TICK;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_ch         <= '0;
            r_sample     <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_triggered  <= 1'b0;
            r_post       <= '0;
            r_addr       <= '0;
            r_trig_addr  <= '0;
            r_capturing  <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_div <= (!r_capturing || w_tick) ? 16'd0 : r_div + 16'd1;
            // Ticks are only consumed in WAIT_TICK; anything else is lost
            if (w_tick && r_state != S_WAIT_TICK)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_arm) begin
                        r_addr       <= '0;
                        r_trig_addr  <= '0;
                        r_overrun    <= 1'b0;
                        r_done       <= 1'b0;
                        r_triggered  <= 1'b0;
                        r_post       <= '0;
                        r_prev_valid <= 1'b0;
                        r_capturing  <= 1'b1;
                    end
                end
                S_WAIT_TICK: begin
                    if (w_tick && w_first[2]) r_ch <= w_first[1:0];
                end
                S_WAIT_DONE: begin
                    if (adc_if.adc_done)
                        r_sample <= adc_if.adc_data;
                    else if (w_timeout && w_above[2])
                        r_ch <= w_above[1:0];
                end
                S_STORE: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_ch == i_trig_ch) begin
                        r_prev       <= r_sample;
                        r_prev_valid <= 1'b1;
                    end
                    if (w_fire) begin
                        r_triggered <= 1'b1;
                        r_trig_addr <= r_addr;
                    end
                    if (w_trig_now) r_post <= r_post + 1'b1;
                    if (w_last) begin
                        r_done      <= 1'b1;
                        r_capturing <= 1'b0;
                    end else if (w_above[2]) begin
                        r_ch <= w_above[1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign adc_if.adc_req = w_req;
    assign adc_if.adc_ch  = r_ch;
    assign o_wr_en        = w_wr_en;
    assign o_wr_addr      = r_addr;
    assign o_wr_data      = {r_ch, r_sample};
    assign o_trig_addr    = r_trig_addr;
    assign o_capturing    = r_capturing;
    assign o_capture_done = r_done;
    assign o_overrun      = r_overrun;
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler with a 3-clk ADC reader model.
// Expected requests/writes are queued by the stimulus and popped by monitors.
module tb_adc_sample_scheduler;
    localparam int AW = 3;

    typedef struct {
        logic [AW-1:0] a;
        logic [13:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic [3:0]    ch_mask = '0;
    logic [1:0]    trig_ch = '0;
    logic [11:0]   trig_level = '0;
    logic [15:0]   rate_div = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [13:0]   wr_data;
    logic [AW-1:0] trig_addr;
    logic          capturing, capture_done, overrun, timeout_err;

    adc_sample_scheduler_if u_if ();

    adc_sample_scheduler #(
        .ADDR_W(AW), .POST_CNT(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .i_arm(arm), .i_ch_mask(ch_mask),
        .i_trig_ch(trig_ch), .i_trig_level(trig_level),
        .i_rate_div(rate_div), .adc_if(u_if),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_trig_addr(trig_addr), .o_capturing(capturing),
        .o_capture_done(capture_done), .o_overrun(overrun),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -10;
    logic model_en = 1'b1;

    logic [1:0]  exp_req_q[$];
    logic [11:0] samp_q[$];
    wr_t         exp_wr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC reader model: answers each request 3 clk later
    initial begin
        logic [1:0] ch;
        u_if.adc_done = 1'b0;
        u_if.adc_data = '0;
        forever begin
            @(negedge clk);
            if (u_if.adc_req && model_en && !rst) begin
                ch = u_if.adc_ch;
                repeat (3) @(negedge clk);
                if (!rst && capturing)
                    chk("adc_ch_hold", 32'(u_if.adc_ch), 32'(ch));
                u_if.adc_data = (samp_q.size() > 0) ? samp_q.pop_front() : 12'h0;
                u_if.adc_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                u_if.adc_done = 1'b0;
            end
        end
    end

    // Monitor: requests and RAM writes against the queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.adc_req) begin
                chk("req_expected", 32'(exp_req_q.size() > 0), 32'd1);
                if (exp_req_q.size() > 0)
                    chk("req_ch", 32'(u_if.adc_ch), 32'(exp_req_q.pop_front()));
            end
            if (wr_en) begin
                wr_t e;
                chk("wr_latency", 32'(cyc - done_cyc), 32'd1);
                chk("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_trig_addr"}, 32'(trig_addr), 32'd0);
        chk({tag, "_capturing"}, 32'(capturing), 32'd0);
        chk({tag, "_done"}, 32'(capture_done), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
        chk({tag, "_adc_req"}, 32'(u_if.adc_req), 32'd0);
        chk({tag, "_adc_ch"}, 32'(u_if.adc_ch), 32'd0);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns inside the STORE cycle of the last expected write
    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while ((exp_wr_q.size() != 0 || exp_req_q.size() != 0) && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_wr_q.size() + exp_req_q.size()), 32'd0);
    endtask

    task automatic push_wr(input int a, input logic [1:0] ch,
                           input logic [11:0] s);
        wr_t w;
        w.a = AW'(a);
        w.d = {ch, s};
        exp_wr_q.push_back(w);
        exp_req_q.push_back(ch);
        samp_q.push_back(s);
    endtask

    initial begin
        logic [11:0] trig_samples [7];
        repeat (2) @(negedge clk);
        #1 chk_zero_outputs("reset");
        rst = 1'b0;

        // Empty mask: capturing but never requesting
        ch_mask  = 4'b0000;
        rate_div = 16'd2;
        @(negedge clk);
        #1 pulse_arm();
        repeat (30) @(negedge clk);
        #1 chk("nomask_capturing", 32'(capturing), 32'd1);
        do_reset(2);

        // Two-channel scan, lowest first, ring address increments
        ch_mask    = 4'b0101;
        rate_div   = 16'd9;
        trig_ch    = 2'd3;
        trig_level = 12'h000;
        for (int i = 0; i < 6; i++)
            push_wr(i, (i % 2 == 0) ? 2'd0 : 2'd2, 12'hA10 + 12'(i));
        @(negedge clk);
        #1 pulse_arm();
        wait_drain("scan", 600);
        // Reset lands mid-scan while the last write is on the bus
        rst = 1'b1;
        #1 chk_zero_outputs("midscan_rst");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;

        // Single channel at full rate: address wrap and overrun
        ch_mask  = 4'b0001;
        rate_div = 16'd0;
        for (int i = 0; i < 10; i++)
            push_wr(i % 8, 2'd0, 12'h010 + 12'(i));
        pulse_arm();
        wait_drain("wrap", 600);
        chk("wrap_overrun", 32'(overrun), 32'd1);
        do_reset(2);

        // Trigger: no fire on invalid prev or without crossing
        trig_samples = '{12'h900, 12'h900, 12'h7FF, 12'h800,
                         12'h100, 12'h200, 12'h300};
        ch_mask    = 4'b0001;
        rate_div   = 16'd20;
        trig_ch    = 2'd0;
        trig_level = 12'h800;
        for (int i = 0; i < 7; i++)
            push_wr(i, 2'd0, trig_samples[i]);
        @(negedge clk);
        #1 pulse_arm();
        wait_drain("trig", 900);
        @(negedge clk);
        #1;
        chk("trig_addr", 32'(trig_addr), 32'd3);
        chk("trig_done", 32'(capture_done), 32'd1);
        chk("trig_capturing", 32'(capturing), 32'd0);
        chk("trig_overrun", 32'(overrun), 32'd0);
        chk("trig_timeout", 32'(timeout_err), 32'd0);
        repeat (60) @(negedge clk);
        #1 chk("done_sticky", 32'(capture_done), 32'd1);
        pulse_arm();
        chk("rearm_done_clr", 32'(capture_done), 32'd0);
        chk("rearm_capturing", 32'(capturing), 32'd1);
        do_reset(2);

`ifdef ADC_TIMEOUT_EN
        // Silent ADC: watchdog fires after 16 clk, next channel follows
        begin
            int n = 0;
            model_en   = 1'b0;
            ch_mask    = 4'b0101;
            rate_div   = 16'd100;
            trig_ch    = 2'd3;
            exp_req_q.push_back(2'd0);
            exp_req_q.push_back(2'd2);
            @(negedge clk);
            #1 pulse_arm();
            while (!u_if.adc_req && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("to_first_req", 32'(u_if.adc_req), 32'd1);
            repeat (16) @(negedge clk);
            #1 chk("to_before", 32'(timeout_err), 32'd0);
            @(negedge clk);
            #1;
            chk("to_flag", 32'(timeout_err), 32'd1);
            chk("to_next_req", 32'(u_if.adc_req), 32'd1);
            chk("to_req_q", 32'(exp_req_q.size()), 32'd0);
            do_reset(2);
            model_en = 1'b1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
